// File: rtl/code_lock_pkg.sv
// Shared state encoding and seven-segment glyphs for the code lock reader.
package code_lock_pkg;

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        FAIL    = 3'd3,
        LOCKOUT = 3'd4
    } lockState_t;

    // Active-low segment patterns, bit i = segment a..g, bit 7 = DP (off).
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;
    localparam logic [7:0] GLYPH_O     = 8'hC0;
    localparam logic [7:0] GLYPH_P     = 8'h8C;
    localparam logic [7:0] GLYPH_E     = 8'h86;
    localparam logic [7:0] GLYPH_N     = 8'hAB;
    localparam logic [7:0] GLYPH_R     = 8'hAF;

    function automatic logic [7:0] hexGlyph(input logic [3:0] digit);
        logic [7:0] glyph;
        case (digit)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises one active-low push-button, debounces it and emits a single
// one-cycle pulse for every accepted press.
module key_debounce
    import code_lock_pkg::*;
#(
    parameter int DB = 2
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic keyN_i,
    output logic press_o
);

    localparam int CNT_W = (DB > 1) ? $clog2(DB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count consecutive cycles of disagreement; accept the new level after DB of them.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        count_d = '0;
        if (sync2_q != level_q) begin
            if (count_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Two-flop synchroniser plus debounce state; everything idles at "released".
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= keyN_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            count_q <= count_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/code_lock_reader.sv
// Board-level code lock: collects four hex digits from the switches on KEY[0]
// presses, compares them against CODE and shows progress/result on HEX3..HEX0.
module code_lock_reader
    import code_lock_pkg::*;
#(
    parameter int          CLK_HZ      = 50000000,
    parameter int          DEBOUNCE_MS = 20,
    parameter logic [15:0] CODE        = 16'h2024,
    parameter int          HOLD_S      = 5,
    parameter int          FAIL_S      = 1,
    parameter int          MAX_FAIL    = 3,
    parameter int          LOCKOUT_S   = 10
) (
    input  logic       CLOCK_50,
    input  logic [4:0] SW,
    input  logic [1:0] KEY,
    output logic [7:0] HEX3,
    output logic [7:0] HEX2,
    output logic [7:0] HEX1,
    output logic [7:0] HEX0,
    output logic       LEDG,
    output logic       LEDR
);

    localparam int DB_RAW  = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DB      = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SEC_MAX = (HOLD_S > FAIL_S) ? ((HOLD_S > LOCKOUT_S) ? HOLD_S : LOCKOUT_S)
                                               : ((FAIL_S > LOCKOUT_S) ? FAIL_S : LOCKOUT_S);
    localparam int SEC_W   = $clog2(SEC_MAX + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0]  SEC_HOLD   = SEC_W'(HOLD_S);
    localparam logic [SEC_W-1:0]  SEC_FAIL   = SEC_W'(FAIL_S);
    localparam logic [SEC_W-1:0]  SEC_LOCK   = SEC_W'(LOCKOUT_S);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

    logic reset;
    logic enterPress;
    logic clearPress;

    lockState_t        state_q;
    lockState_t        state_d;
    logic [1:0]        idx_q;
    logic [1:0]        idx_d;
    logic [3:0][3:0]   digits_q;
    logic [3:0][3:0]   digits_d;
    logic [FAIL_W-1:0] failCnt_q;
    logic [FAIL_W-1:0] failCnt_d;
    logic [PRE_W-1:0]  prescale_q;
    logic [PRE_W-1:0]  prescale_d;
    logic [SEC_W-1:0]  seconds_q;
    logic [SEC_W-1:0]  seconds_d;

    logic [FAIL_W-1:0] failInc;
    logic [SEC_W-1:0]  secNext;
    logic [SEC_W-1:0]  secLimit;
    logic [15:0]       enteredCode;

    logic [3:0][7:0]   hex_q;
    logic [3:0][7:0]   hex_d;
    logic              ledg_q;
    logic              ledg_d;
    logic              ledr_q;
    logic              ledr_d;

    assign reset = SW[0];

    key_debounce #(.DB(DB)) u_keyEnter (
        .clock_i (CLOCK_50),
        .reset_i (reset),
        .keyN_i  (KEY[0]),
        .press_o (enterPress)
    );

    key_debounce #(.DB(DB)) u_keyClear (
        .clock_i (CLOCK_50),
        .reset_i (reset),
        .keyN_i  (KEY[1]),
        .press_o (clearPress)
    );

    // Digit position 0 is the leftmost display and the most significant nibble.
    assign enteredCode = {digits_q[0], digits_q[1], digits_q[2], digits_q[3]};

    // Next-state logic: digit entry, one-cycle compare, and the seconds-timed states.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        digits_d   = digits_q;
        failCnt_d  = failCnt_q;
        prescale_d = prescale_q;
        seconds_d  = seconds_q;
        failInc    = (failCnt_q == '1) ? failCnt_q : failCnt_q + 1'b1;
        secNext    = seconds_q + 1'b1;
        secLimit   = SEC_HOLD;
        case (state_q)
            ENTRY: begin
                if (clearPress) begin
                    idx_d    = '0;
                    digits_d = '0;
                end else if (enterPress) begin
                    digits_d[idx_q] = SW[4:1];
                    idx_d           = idx_q + 1'b1;
                    if (idx_q == 2'd3) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                idx_d      = '0;
                digits_d   = '0;
                prescale_d = '0;
                seconds_d  = '0;
                if (enteredCode == CODE) begin
                    state_d   = OPEN;
                    failCnt_d = '0;
                end else begin
                    failCnt_d = failInc;
                    state_d   = (failInc == FAIL_LIMIT) ? LOCKOUT : FAIL;
                end
            end
            OPEN, FAIL, LOCKOUT: begin
                if (state_q == FAIL) begin
                    secLimit = SEC_FAIL;
                end else if (state_q == LOCKOUT) begin
                    secLimit = SEC_LOCK;
                end
                if (prescale_q == PRE_LAST) begin
                    prescale_d = '0;
                    seconds_d  = secNext;
                    if (secNext == secLimit) begin
                        state_d   = ENTRY;
                        seconds_d = '0;
                        if (state_q == LOCKOUT) begin
                            failCnt_d = '0;
                        end
                    end
                end else begin
                    prescale_d = prescale_q + 1'b1;
                end
            end
            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    // Lock state, entered digits, failure count and seconds timer.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ENTRY;
            idx_q      <= '0;
            digits_q   <= '0;
            failCnt_q  <= '0;
            prescale_q <= '0;
            seconds_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            digits_q   <= digits_d;
            failCnt_q  <= failCnt_d;
            prescale_q <= prescale_d;
            seconds_q  <= seconds_d;
        end
    end

    // Display content for the current state; CHECK still shows all four digits.
    always_comb begin
        hex_d  = {4{GLYPH_BLANK}};
        ledg_d = 1'b0;
        ledr_d = 1'b0;
        case (state_q)
            ENTRY: begin
                for (int k = 0; k < 4; k++) begin
                    if (k < int'(idx_q)) begin
                        hex_d[k[1:0]] = hexGlyph(digits_q[k[1:0]]);
                    end
                end
            end
            CHECK: begin
                for (int k = 0; k < 4; k++) begin
                    hex_d[k[1:0]] = hexGlyph(digits_q[k[1:0]]);
                end
            end
            OPEN: begin
                hex_d[0] = GLYPH_O;
                hex_d[1] = GLYPH_P;
                hex_d[2] = GLYPH_E;
                hex_d[3] = GLYPH_N;
                ledg_d   = 1'b1;
            end
            FAIL: begin
                hex_d[0] = GLYPH_E;
                hex_d[1] = GLYPH_R;
                hex_d[2] = GLYPH_R;
                hex_d[3] = GLYPH_BLANK;
            end
            LOCKOUT: begin
                hex_d  = {4{GLYPH_DASH}};
                ledr_d = 1'b1;
            end
            default: begin
                hex_d = {4{GLYPH_BLANK}};
            end
        endcase
    end

    // Registered board outputs, one cycle behind the state they describe.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hex_q  <= {4{GLYPH_BLANK}};
            ledg_q <= 1'b0;
            ledr_q <= 1'b0;
        end else begin
            hex_q  <= hex_d;
            ledg_q <= ledg_d;
            ledr_q <= ledr_d;
        end
    end

    assign HEX3 = hex_q[0];
    assign HEX2 = hex_q[1];
    assign HEX1 = hex_q[2];
    assign HEX0 = hex_q[3];
    assign LEDG = ledg_q;
    assign LEDR = ledr_q;

endmodule

// File: tb/tb_code_lock_reader.sv
// Scenario bench for code_lock_reader with a 1 kHz clock so seconds are short.
module tb_code_lock_reader;

    localparam int          CLK_HZ      = 1000;
    localparam int          DEBOUNCE_MS = 2;
    localparam int          DB          = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int          HOLD_S      = 2;
    localparam int          FAIL_S      = 1;
    localparam int          LOCKOUT_S   = 3;
    localparam int          MAX_FAIL    = 3;
    localparam logic [15:0] CODE        = 16'h2024;

    localparam logic [31:0] VIEW_BLANK = 32'hFFFF_FFFF;
    localparam logic [31:0] VIEW_OPEN  = 32'hC08C_86AB;
    localparam logic [31:0] VIEW_ERR   = 32'h86AF_AFFF;
    localparam logic [31:0] VIEW_LOCK  = 32'hBFBF_BFBF;

    logic       clock = 1'b0;
    logic [4:0] sw    = 5'b00001;
    logic [1:0] key   = 2'b11;
    logic [7:0] hex3;
    logic [7:0] hex2;
    logic [7:0] hex1;
    logic [7:0] hex0;
    logic       ledg;
    logic       ledr;

    typedef struct {
        string       name;
        logic [31:0] hex;
        logic        ledg;
        logic        ledr;
    } expect_t;

    expect_t    expQ[$];
    logic [3:0] model[$];
    int         errors = 0;
    int         checks = 0;

    code_lock_reader #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .CODE        (CODE),
        .HOLD_S      (HOLD_S),
        .FAIL_S      (FAIL_S),
        .MAX_FAIL    (MAX_FAIL),
        .LOCKOUT_S   (LOCKOUT_S)
    ) dut (
        .CLOCK_50 (clock),
        .SW       (sw),
        .KEY      (key),
        .HEX3     (hex3),
        .HEX2     (hex2),
        .HEX1     (hex1),
        .HEX0     (hex0),
        .LEDG     (ledg),
        .LEDR     (ledr)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [31:0] entryView();
        logic [31:0] v;
        v = VIEW_BLANK;
        for (int k = 0; k < model.size() && k < 4; k++) begin
            v[31 - 8 * k -: 8] = glyph(model[k]);
        end
        return v;
    endfunction

    task automatic pushExpect(input string name, input logic [31:0] hex, input logic eLedg, input logic eLedr);
        expect_t e;
        e.name = name;
        e.hex  = hex;
        e.ledg = eLedg;
        e.ledr = eLedr;
        expQ.push_back(e);
    endtask

    // Drive a press, update the digit model and queue the display expected 6 cycles later.
    task automatic pressKeys(input logic [1:0] mask, input logic [3:0] val, input string name);
        @(negedge clock);
        sw[4:1] = val;
        key     = ~mask;
        if (mask[1]) begin
            model.delete();
        end else if (mask[0]) begin
            model.push_back(val);
        end
        pushExpect(name, entryView(), 1'b0, 1'b0);
        if (model.size() == 4) begin
            model.delete();
        end
        repeat (6) @(negedge clock);
    endtask

    task automatic releaseKeys();
        key = 2'b11;
        repeat (DB + 4) @(negedge clock);
    endtask

    task automatic test_reset();
        expect_t e;
        sw  = 5'b00001;
        key = 2'b11;
        pushExpect("reset view", VIEW_BLANK, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        e = expQ.pop_front();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
            errors++;
            $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                     e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
        end
        checks++;
        if (dut.failCnt_q !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset fail count: got %0d, want 0", dut.failCnt_q);
        end
        sw[0] = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_bounce();
        expect_t e;
        int      pulses;
        int      firstAt;
        pulses  = 0;
        firstAt = -1;
        @(negedge clock);
        sw[4:1] = 4'h2;
        for (int i = 0; i < 4; i++) begin
            key[0] = (i % 2 == 1);
            @(negedge clock);
            if (dut.enterPress === 1'b1) pulses++;
        end
        key[0] = 1'b0;
        model.push_back(4'h2);
        pushExpect("bounce digit", entryView(), 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (dut.enterPress === 1'b1) begin
                pulses++;
                if (firstAt < 0) firstAt = i;
            end
            if (i == 6) begin
                e = expQ.pop_front();
                checks++;
                if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
                    errors++;
                    $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                             e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL bounce pulse count: got %0d, want 1", pulses);
        end
        checks++;
        if (firstAt != DB + 2) begin
            errors++;
            $display("[TB] FAIL bounce pulse latency: got %0d, want %0d", firstAt, DB + 2);
        end
        releaseKeys();
    endtask

    task automatic test_clear_then_open();
        expect_t    e;
        int         cnt;
        logic [3:0] seq [4];
        seq = '{4'h2, 4'h0, 4'h2, 4'h4};
        pressKeys(2'b01, 4'h0, "second digit before clear");
        e = expQ.pop_front();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
            errors++;
            $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                     e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
        end
        releaseKeys();
        pressKeys(2'b10, 4'h0, "clear blanks");
        e = expQ.pop_front();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
            errors++;
            $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                     e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
        end
        releaseKeys();
        for (int i = 0; i < 4; i++) begin
            pressKeys(2'b01, seq[i], $sformatf("code digit %0d", i));
            e = expQ.pop_front();
            checks++;
            if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
                errors++;
                $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                         e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
            end
            if (i < 3) releaseKeys();
        end
        key = 2'b11;
        pushExpect("open view", VIEW_OPEN, 1'b1, 1'b0);
        @(negedge clock);
        e = expQ.pop_front();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
            errors++;
            $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                     e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
        end
        cnt = 0;
        while (ledg === 1'b1 && cnt < 2 * HOLD_S * CLK_HZ) begin
            cnt++;
            @(negedge clock);
        end
        checks++;
        if (cnt != HOLD_S * CLK_HZ) begin
            errors++;
            $display("[TB] FAIL open duration: got %0d cycles, want %0d", cnt, HOLD_S * CLK_HZ);
        end
        pushExpect("after open", VIEW_BLANK, 1'b0, 1'b0);
        e = expQ.pop_front();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
            errors++;
            $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                     e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
        end
    endtask

    task automatic test_fail_lockout();
        expect_t     e;
        int          cnt;
        int          limit;
        logic [31:0] view;
        for (int round = 0; round < 3; round++) begin
            for (int d = 0; d < 4; d++) begin
                pressKeys(2'b01, 4'h1, $sformatf("wrong digit r%0d d%0d", round, d));
                e = expQ.pop_front();
                checks++;
                if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
                    errors++;
                    $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                             e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
                end
                if (d < 3) releaseKeys();
            end
            key   = 2'b11;
            view  = (round < 2) ? VIEW_ERR : VIEW_LOCK;
            limit = (round < 2) ? FAIL_S * CLK_HZ : LOCKOUT_S * CLK_HZ;
            pushExpect($sformatf("mismatch view r%0d", round), view, 1'b0, round == 2);
            @(negedge clock);
            e = expQ.pop_front();
            checks++;
            if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
                errors++;
                $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                         e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
            end
            cnt = 0;
            while ({hex3, hex2, hex1, hex0} === view && cnt < 2 * limit) begin
                if (round == 2 && cnt == 500) begin
                    sw[4:1] = 4'h5;
                    key[0]  = 1'b0;
                end
                if (cnt == 520) key[0] = 1'b1;
                cnt++;
                @(negedge clock);
            end
            checks++;
            if (cnt != limit) begin
                errors++;
                $display("[TB] FAIL timed state r%0d duration: got %0d cycles, want %0d", round, cnt, limit);
            end
        end
        checks++;
        if (dut.failCnt_q !== 2'd0) begin
            errors++;
            $display("[TB] FAIL lockout exit fail count: got %0d, want 0", dut.failCnt_q);
        end
        pressKeys(2'b01, 4'h7, "first digit after lockout");
        e = expQ.pop_front();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
            errors++;
            $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                     e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
        end
        releaseKeys();
        pressKeys(2'b10, 4'h0, "clear after lockout");
        e = expQ.pop_front();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
            errors++;
            $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                     e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
        end
        releaseKeys();
    endtask

    task automatic test_back_to_back_keys();
        expect_t    e;
        logic [1:0] masks [5];
        logic [3:0] vals  [5];
        masks = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b10};
        vals  = '{4'h3, 4'h5, 4'h9, 4'h6, 4'h0};
        for (int i = 0; i < 5; i++) begin
            pressKeys(masks[i], vals[i], $sformatf("simultaneous step %0d", i));
            e = expQ.pop_front();
            checks++;
            if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
                errors++;
                $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                         e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
            end
            releaseKeys();
        end
    endtask

    task automatic test_reset_mid_lockout();
        expect_t e;
        int      cnt;
        for (int round = 0; round < 3; round++) begin
            for (int d = 0; d < 4; d++) begin
                pressKeys(2'b01, 4'h1, $sformatf("lockout run r%0d d%0d", round, d));
                e = expQ.pop_front();
                checks++;
                if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
                    errors++;
                    $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                             e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
                end
                if (d < 3) releaseKeys();
            end
            key = 2'b11;
            @(negedge clock);
            cnt = 0;
            while (round < 2 && {hex3, hex2, hex1, hex0} === VIEW_ERR && cnt < 2 * FAIL_S * CLK_HZ) begin
                cnt++;
                @(negedge clock);
            end
        end
        repeat (100) @(negedge clock);
        pushExpect("in lockout before reset", VIEW_LOCK, 1'b0, 1'b1);
        e = expQ.pop_front();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
            errors++;
            $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                     e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
        end
        sw[0] = 1'b1;
        pushExpect("reset mid lockout", VIEW_BLANK, 1'b0, 1'b0);
        @(negedge clock);
        sw[0] = 1'b0;
        e = expQ.pop_front();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
            errors++;
            $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                     e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
        end
        checks++;
        if (dut.failCnt_q !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset mid lockout fail count: got %0d, want 0", dut.failCnt_q);
        end
        for (int d = 0; d < 4; d++) begin
            pressKeys(2'b01, 4'h1, $sformatf("after reset d%0d", d));
            void'(expQ.pop_front());
            if (d < 3) releaseKeys();
        end
        key = 2'b11;
        pushExpect("single mismatch after reset", VIEW_ERR, 1'b0, 1'b0);
        @(negedge clock);
        e = expQ.pop_front();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== e.hex || ledg !== e.ledg || ledr !== e.ledr) begin
            errors++;
            $display("[TB] FAIL %s: got hex=%h ledg=%b ledr=%b, want hex=%h ledg=%b ledr=%b",
                     e.name, {hex3, hex2, hex1, hex0}, ledg, ledr, e.hex, e.ledg, e.ledr);
        end
        cnt = 0;
        while ({hex3, hex2, hex1, hex0} === VIEW_ERR && cnt < 2 * FAIL_S * CLK_HZ) begin
            cnt++;
            @(negedge clock);
        end
    endtask

    initial begin
        $display("[TB] code_lock_reader bench, DB=%0d cycles", DB);
        test_reset();
        test_bounce();
        test_clear_then_open();
        test_fail_lockout();
        test_back_to_back_keys();
        test_reset_mid_lockout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/code_lock_reader.md
Name: code_lock_reader

Overview:
- Input-side companion to the team's HEX display FSMs: reads the operator through switches and push-buttons and checks an entered code.
- KEY presses are synchronised and debounced, and each press captures a 4-bit hex digit from SW[4:1].
- Four captured digits are compared against a parameterised code.
- Digits and lock status are shown on HEX3..HEX0 and LEDs; the block sits at top level on the DE-series board.

Parameters:
CLK_HZ, 50000000, CLOCK_50 frequency; sets the 1 s prescaler.
DEBOUNCE_MS, 20, required stable time before a KEY level is accepted.
CODE, 16'h2024, unlock code; HEX3 digit = CODE[15:12] ... HEX0 digit = CODE[3:0].
HOLD_S, 5, seconds spent in OPEN.
FAIL_S, 1, seconds spent in FAIL.
MAX_FAIL, 3, consecutive mismatches that trigger LOCKOUT.
LOCKOUT_S, 10, seconds spent in LOCKOUT.

Ports:
CLOCK_50  input  1  system clock; the only clock.
SW        input  5  SW[0] = reset, synchronous, active-high; SW[4:1] = digit value.
KEY       input  2  active-low buttons, asynchronous to CLOCK_50; KEY[0] = enter digit, KEY[1] = clear.
HEX3..HEX0 output 8 each  active-low 7-seg; bit i = segment a..g for i = 0..6; bit7 = DP (always 1).
LEDG      output 1  high while OPEN.
LEDR      output 1  high while LOCKOUT.

Behaviour:
- Reset (SW[0] = 1 at a CLOCK_50 edge):
  - state = ENTRY, idx = 0, fail_cnt = 0, digits cleared.
  - HEX3..0 = 8'hFF, LEDG = 0, LEDR = 0.
  - Synchroniser and debounce registers = 1 (released).
  - Reset mid-OPEN, FAIL or LOCKOUT returns to ENTRY with fail_cnt = 0.
- KEY path, per button:
  - Two-flop synchroniser.
  - Debounce counter runs while the synced level differs from the accepted level; it clears whenever they match.
  - After DB = CLK_HZ/1000*DEBOUNCE_MS consecutive differing cycles, the accepted level updates.
  - An accepted 1->0 transition emits a 1-cycle press pulse.
  - Release generates no event; a held key generates exactly one pulse.
- State ENTRY:
  - Enter pulse stores SW[4:1] into digit[idx] and increments idx.
  - When the 4th digit is stored (idx was 3), the next cycle performs the compare.
  - Clear pulse sets idx = 0 and blanks all digits.
  - Enter and clear pulses in the same cycle: clear wins, no digit is stored.
- Compare, one cycle:
  - Match: go to OPEN, fail_cnt = 0.
  - Mismatch: fail_cnt + 1; if the new value equals MAX_FAIL go to LOCKOUT, else go to FAIL.
  - idx returns to 0 and digits are cleared in both cases.
- Timed states:
  - OPEN lasts HOLD_S seconds, FAIL lasts FAIL_S seconds, LOCKOUT lasts LOCKOUT_S seconds.
  - All presses are ignored in these states.
  - A seconds timer (CLK_HZ-cycle prescaler plus seconds counter) restarts on state entry.
  - Exit to ENTRY happens exactly N*CLK_HZ cycles after entry.
  - LOCKOUT exit clears fail_cnt.
- Outputs, registered (1 cycle after the state/digit update):
  - ENTRY: position k (HEX3 = position 0) shows the hex glyph of digit[k] if k < idx, else 8'hFF.
  - OPEN: "OPEn" = C0, 8C, 86, AB; LEDG = 1.
  - FAIL: "Err " = 86, AF, AF, FF.
  - LOCKOUT: "----" = BF x4; LEDR = 1.
- Widths: idx 2 bits; fail_cnt $clog2(MAX_FAIL+1) bits, saturating; prescaler $clog2(CLK_HZ) bits.

Decomposition:
- Package code_lock_pkg:
  - State encoding: ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
  - 16-entry hex glyph table (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E).
  - Glyph constants BLANK=FF, DASH=BF, O=C0, P=8C, n=AB, r=AF.
- Sub-module key_debounce (parameter DB), instantiated once per KEY:
  - Synchroniser, debounce counter, press pulse.

Test Plan (CLK_HZ=1000, DEBOUNCE_MS=2 so DB=2; HOLD_S=2, FAIL_S=1, LOCKOUT_S=3; CODE=16'h2024):
- Reset mid-LOCKOUT: assert SW[0] for 1 cycle -> next cycle state ENTRY, HEX all FF, LEDR=0, fail_cnt=0.
- Bouncing KEY[0]: low 1 cycle, high 1, low 1, high 1, then low 10 cycles -> exactly one press pulse, asserted DB+2 cycles after the last falling edge; one digit stored.
- Enter 2,0,2,4 -> HEX3..0 show A4, C0, A4, 99 progressively; then OPEN: HEX C0,8C,86,AB and LEDG=1 for exactly 2000 cycles; then ENTRY with HEX all FF.
- Enter 1,1,1,1 -> FAIL, HEX 86,AF,AF,FF for 1000 cycles; repeat twice more -> third mismatch gives LOCKOUT, HEX BF x4, LEDR=1 for 3000 cycles; presses during LOCKOUT store nothing.
- Enter 2,0, press clear, then enter 2,0,2,4 -> HEX blanks after clear; sequence still opens.
- KEY[0] and KEY[1] accepted in the same cycle with idx=2 -> idx=0, HEX all FF, no digit stored.
